// File: rtl/oam_line_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : oam_line_scheduler_if
// Purpose  : Bundles the OAM read port and the committed slot bank of the
//            per-scanline sprite scheduler.
// Ports    : (interface signals)
//            oam_addr   - OAM read address, data returns one cycle later
//            oam_data   - OAM read data
//            slot_data  - committed entries, slot k = [32k+31:32k]
//            slot_valid - per-slot valid for the current line
//            hit_count  - committed hits, saturated at SLOTS
//            overflow   - last committed line had more than SLOTS hits
//            line_ready - one-cycle pulse on commit
//            scan_busy  - scheduler is scanning / draining / committing
//            Modports: master = scheduler side, slave = OAM / engine side.
// Revision : 1.0 - initial release
// ============================================================================
interface oam_line_scheduler_if #(
  parameter int OAM_AW = 3,
  parameter int SLOTS  = 4
);
  logic [OAM_AW-1:0]   oam_addr;
  logic [31:0]         oam_data;
  logic [SLOTS*32-1:0] slot_data;
  logic [SLOTS-1:0]    slot_valid;
  logic [2:0]          hit_count;
  logic                overflow;
  logic                line_ready;
  logic                scan_busy;

  modport master (
    output oam_addr,
    input  oam_data,
    output slot_data,
    output slot_valid,
    output hit_count,
    output overflow,
    output line_ready,
    output scan_busy
  );

  modport slave (
    input  oam_addr,
    output oam_data,
    input  slot_data,
    input  slot_valid,
    input  hit_count,
    input  overflow,
    input  line_ready,
    input  scan_busy
  );
endinterface
`default_nettype wire

// File: rtl/oam_line_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : oam_line_scheduler
// Purpose  : Per-scanline sprite scheduler. On each horizontal blank it scans
//            the whole OAM, picks the first SLOTS enabled objects overlapping
//            the next scanline and commits them atomically to a slot bank that
//            feeds one sprite engine per slot. Lines carrying more than SLOTS
//            sprites are flagged via overflow.
// Ports    : clk    - pixel clock
//            rst_n  - asynchronous active-low reset
//            x_i    - current pixel column
//            y_i    - current line
//            bus    - OAM read port and committed slot bank (master modport)
// Revision : 1.0 - initial release
// ============================================================================
module oam_line_scheduler #(
  parameter int OAM_DEPTH   = 8,
  parameter int OAM_AW      = 3,
  parameter int SLOTS       = 4,
  parameter int TILE_HEIGHT = 32,
  parameter int H_ACTIVE    = 640,
  parameter int H_TOTAL     = 800,
  parameter int V_ACTIVE    = 480,
  parameter int V_TOTAL     = 525
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [9:0]                 x_i,
  input  logic [9:0]                 y_i,
  oam_line_scheduler_if.master       bus
);

  // --------------------------------------------------------------------------
  // Elaboration-time sanity: the whole scan plus commit must fit in blanking,
  // and the 3-bit hit counter must be able to hold SLOTS.
  // --------------------------------------------------------------------------
  if (OAM_DEPTH + 3 > H_TOTAL - H_ACTIVE) begin : g_bad_blanking
    $error("oam_line_scheduler: horizontal blanking too short for OAM scan");
  end
  if (SLOTS > 7) begin : g_bad_slots
    $error("oam_line_scheduler: SLOTS must fit the 3-bit hit counter");
  end

  localparam logic [OAM_AW-1:0] LAST_ADDR  = OAM_AW'(OAM_DEPTH - 1);
  localparam logic [9:0]        TRIG_X     = 10'(H_ACTIVE);
  localparam logic [9:0]        LAST_LINE  = 10'(V_TOTAL - 1);
  localparam logic [9:0]        VIS_LINES  = 10'(V_ACTIVE);
  localparam logic [10:0]       TILE_H11   = 11'(TILE_HEIGHT);
  localparam logic [2:0]        SLOTS_CNT  = 3'(SLOTS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_DRAIN  = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [OAM_AW-1:0]     addr_q, addr_d;
  logic [9:0]            tgt_y_q, tgt_y_d;
  logic [2:0]            cnt_q, cnt_d;        // running hit count for the line
  logic                  ovf_q, ovf_d;        // shadow overflow flag
  logic [31:0]           shadow_q [SLOTS];
  logic [31:0]           shadow_d [SLOTS];

  logic [SLOTS*32-1:0]   slot_data_q, slot_data_d;
  logic [SLOTS-1:0]      slot_valid_q, slot_valid_d;
  logic [2:0]            hit_count_q, hit_count_d;
  logic                  overflow_q, overflow_d;
  logic                  line_ready_q, line_ready_d;

  // --------------------------------------------------------------------------
  // Hit test on the entry returned by the synchronous OAM read. The entry
  // issued in one cycle is evaluated the next, so evaluation runs in SCAN
  // cycles 1..DEPTH-1 (addr != 0) and in DRAIN for the last entry.
  // --------------------------------------------------------------------------
  logic        eval_en;
  logic        entry_en;
  logic [10:0] py11;
  logic [10:0] ty11;
  logic        hit;

  assign eval_en  = ((state_q == S_SCAN) && (addr_q != '0)) || (state_q == S_DRAIN);
  assign entry_en = bus.oam_data[28];
  // 11-bit compare keeps py + TILE_HEIGHT from wrapping near the top of py.
  assign py11     = {1'b0, bus.oam_data[17:8]};
  assign ty11     = {1'b0, tgt_y_q};
  assign hit      = eval_en && entry_en && (tgt_y_q < VIS_LINES) &&
                    (ty11 >= py11) && (ty11 < py11 + TILE_H11);

  // --------------------------------------------------------------------------
  // Next-state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    tgt_y_d      = tgt_y_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    shadow_d     = shadow_q;
    slot_data_d  = slot_data_q;
    slot_valid_d = slot_valid_q;
    hit_count_d  = hit_count_q;
    overflow_d   = overflow_q;
    line_ready_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (x_i == TRIG_X) begin
          state_d = S_SCAN;
          addr_d  = '0;
          tgt_y_d = (y_i == LAST_LINE) ? 10'd0 : y_i + 10'd1;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          for (int k = 0; k < SLOTS; k++) begin
            shadow_d[k] = '0;
          end
        end
      end
      S_SCAN: begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        state_d = S_COMMIT;
      end
      S_COMMIT: begin
        state_d      = S_IDLE;
        line_ready_d = 1'b1;
        hit_count_d  = cnt_q;
        overflow_d   = ovf_q;
        for (int k = 0; k < SLOTS; k++) begin
          slot_data_d[32*k +: 32] = shadow_q[k];
          slot_valid_d[k]         = (3'(k) < cnt_q);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Hits fill slots in OAM order; the slot index is the running count.
    if (hit) begin
      if (cnt_q == SLOTS_CNT) begin
        ovf_d = 1'b1;
      end else begin
        for (int k = 0; k < SLOTS; k++) begin
          if (cnt_q == 3'(k)) begin
            shadow_d[k] = bus.oam_data;
          end
        end
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      tgt_y_q      <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      for (int k = 0; k < SLOTS; k++) begin
        shadow_q[k] <= '0;
      end
      slot_data_q  <= '0;
      slot_valid_q <= '0;
      hit_count_q  <= '0;
      overflow_q   <= 1'b0;
      line_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      tgt_y_q      <= tgt_y_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      shadow_q     <= shadow_d;
      slot_data_q  <= slot_data_d;
      slot_valid_q <= slot_valid_d;
      hit_count_q  <= hit_count_d;
      overflow_q   <= overflow_d;
      line_ready_q <= line_ready_d;
    end
  end

  assign bus.oam_addr   = addr_q;
  assign bus.slot_data  = slot_data_q;
  assign bus.slot_valid = slot_valid_q;
  assign bus.hit_count  = hit_count_q;
  assign bus.overflow   = overflow_q;
  assign bus.line_ready = line_ready_q;
  assign bus.scan_busy  = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_oam_line_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_oam_line_scheduler
// Purpose  : Directed self-checking bench for oam_line_scheduler. Models a
//            synchronous OAM and checks committed slots, counts, overflow,
//            commit latency, boundaries and reset behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_oam_line_scheduler;

  localparam int OAM_DEPTH = 8;
  localparam int OAM_AW    = 3;
  localparam int SLOTS     = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] x_i;
  logic [9:0] y_i;

  logic [31:0] oam [OAM_DEPTH];

  int tests_run = 0;
  int fails     = 0;

  oam_line_scheduler_if #(.OAM_AW(OAM_AW), .SLOTS(SLOTS)) bus_if ();

  oam_line_scheduler #(
    .OAM_DEPTH  (OAM_DEPTH),
    .OAM_AW     (OAM_AW),
    .SLOTS      (SLOTS),
    .TILE_HEIGHT(32),
    .H_ACTIVE   (640),
    .H_TOTAL    (800),
    .V_ACTIVE   (480),
    .V_TOTAL    (525)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .x_i  (x_i),
    .y_i  (y_i),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  // Synchronous OAM: data for an address appears one cycle after it is issued.
  always @(posedge clk) begin
    bus_if.oam_data <= oam[bus_if.oam_addr];
  end

  // Distinct px/dir/row/col per index so slot contents identify the entry.
  function automatic logic [31:0] make_entry(input int idx, input logic en, input logic [9:0] py);
    return {1'b0, 2'(idx), en, 10'(idx * 37 + 3), py, 8'(idx * 17 + 5)};
  endfunction

  task automatic clear_oam();
    for (int i = 0; i < OAM_DEPTH; i++) oam[i] = make_entry(i, 1'b0, 10'd0);
  endtask

  // Trigger one scan at line yv and return cycles from trigger edge to the
  // line_ready pulse (-1 if it never arrives). Returns #1 after that edge.
  task automatic run_line(input logic [9:0] yv, output int lat);
    lat = -1;
    @(negedge clk);
    x_i = 10'd640;
    y_i = yv;
    @(posedge clk);
    @(negedge clk);
    x_i = 10'd641;
    for (int n = 1; n <= 20; n++) begin
      if (n > 1) @(posedge clk);
      else @(posedge clk);
      #1;
      if (bus_if.line_ready === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    tests_run++;
    if (bus_if.slot_valid !== 4'b0000) begin
      fails++; $display("FAIL reset_slot_valid: got %b expected %b", bus_if.slot_valid, 4'b0000);
    end
    tests_run++;
    if (bus_if.slot_data !== 128'd0) begin
      fails++; $display("FAIL reset_slot_data: got %h expected 0", bus_if.slot_data);
    end
    tests_run++;
    if ({bus_if.hit_count, bus_if.overflow, bus_if.line_ready, bus_if.scan_busy} !== 6'd0) begin
      fails++; $display("FAIL reset_flags: got hc=%0d ovf=%b lr=%b busy=%b expected all 0",
                        bus_if.hit_count, bus_if.overflow, bus_if.line_ready, bus_if.scan_busy);
    end
    tests_run++;
    if (bus_if.oam_addr !== 3'd0) begin
      fails++; $display("FAIL reset_oam_addr: got %0d expected 0", bus_if.oam_addr);
    end
  endtask

  task automatic test_single_hit();
    int lat;
    clear_oam();
    oam[2] = make_entry(2, 1'b1, 10'd100);
    run_line(10'd99, lat);
    tests_run++;
    if (lat !== 10) begin
      fails++; $display("FAIL single_latency: got %0d expected 10", lat);
    end
    tests_run++;
    if (bus_if.slot_valid !== 4'b0001) begin
      fails++; $display("FAIL single_valid: got %b expected 0001", bus_if.slot_valid);
    end
    tests_run++;
    if (bus_if.slot_data[31:0] !== oam[2]) begin
      fails++; $display("FAIL single_slot0: got %h expected %h", bus_if.slot_data[31:0], oam[2]);
    end
    tests_run++;
    if (bus_if.hit_count !== 3'd1 || bus_if.overflow !== 1'b0) begin
      fails++; $display("FAIL single_count: got hc=%0d ovf=%b expected hc=1 ovf=0",
                        bus_if.hit_count, bus_if.overflow);
    end
    @(posedge clk); #1;
    tests_run++;
    if (bus_if.line_ready !== 1'b0 || bus_if.scan_busy !== 1'b0 || bus_if.slot_valid !== 4'b0001) begin
      fails++; $display("FAIL single_pulse_hold: got lr=%b busy=%b valid=%b expected lr=0 busy=0 valid=0001",
                        bus_if.line_ready, bus_if.scan_busy, bus_if.slot_valid);
    end
  endtask

  task automatic test_overflow();
    int lat;
    clear_oam();
    for (int i = 0; i < 6; i++) oam[i] = make_entry(i, 1'b1, 10'd200);
    run_line(10'd210, lat);
    tests_run++;
    if (bus_if.slot_data !== {oam[3], oam[2], oam[1], oam[0]}) begin
      fails++; $display("FAIL ovf_slots: got %h expected %h", bus_if.slot_data, {oam[3], oam[2], oam[1], oam[0]});
    end
    tests_run++;
    if (bus_if.slot_valid !== 4'b1111 || bus_if.hit_count !== 3'd4 || bus_if.overflow !== 1'b1) begin
      fails++; $display("FAIL ovf_flags: got valid=%b hc=%0d ovf=%b expected valid=1111 hc=4 ovf=1",
                        bus_if.slot_valid, bus_if.hit_count, bus_if.overflow);
    end
  endtask

  task automatic test_blank_line();
    int lat;
    clear_oam();
    for (int i = 0; i < 6; i++) oam[i] = make_entry(i, 1'b1, 10'd470);
    run_line(10'd479, lat);
    tests_run++;
    if (lat !== 10) begin
      fails++; $display("FAIL blank_latency: got %0d expected 10", lat);
    end
    tests_run++;
    if (bus_if.slot_valid !== 4'b0000 || bus_if.overflow !== 1'b0 || bus_if.hit_count !== 3'd0) begin
      fails++; $display("FAIL blank_flags: got valid=%b hc=%0d ovf=%b expected valid=0000 hc=0 ovf=0",
                        bus_if.slot_valid, bus_if.hit_count, bus_if.overflow);
    end
  endtask

  // Object at py=100 covers target lines 100..131.
  task automatic test_boundaries();
    int lat;
    logic [9:0] trig_y   [4];
    logic       en_tab   [4];
    logic [3:0] exp_vld  [4];
    trig_y[0] = 10'd98;  en_tab[0] = 1'b1; exp_vld[0] = 4'b0000;
    trig_y[1] = 10'd130; en_tab[1] = 1'b1; exp_vld[1] = 4'b0001;
    trig_y[2] = 10'd131; en_tab[2] = 1'b1; exp_vld[2] = 4'b0000;
    trig_y[3] = 10'd110; en_tab[3] = 1'b0; exp_vld[3] = 4'b0000;
    for (int t = 0; t < 4; t++) begin
      clear_oam();
      oam[2] = make_entry(2, en_tab[t], 10'd100);
      run_line(trig_y[t], lat);
      tests_run++;
      if (bus_if.slot_valid !== exp_vld[t] || lat !== 10) begin
        fails++; $display("FAIL boundary_y%0d: got valid=%b lat=%0d expected valid=%b lat=10",
                          trig_y[t], bus_if.slot_valid, lat, exp_vld[t]);
      end
    end
  endtask

  task automatic test_wrap();
    int lat;
    clear_oam();
    oam[1] = make_entry(1, 1'b1, 10'd1000);
    oam[5] = make_entry(5, 1'b1, 10'd0);
    run_line(10'd7, lat);
    tests_run++;
    if (bus_if.slot_valid !== 4'b0001 || bus_if.slot_data[31:0] !== oam[5]) begin
      fails++; $display("FAIL wrap_py1000: got valid=%b slot0=%h expected valid=0001 slot0=%h",
                        bus_if.slot_valid, bus_if.slot_data[31:0], oam[5]);
    end
    run_line(10'd524, lat);
    tests_run++;
    if (bus_if.slot_valid !== 4'b0001 || bus_if.slot_data[31:0] !== oam[5] || bus_if.hit_count !== 3'd1) begin
      fails++; $display("FAIL wrap_last_line: got valid=%b slot0=%h hc=%0d expected valid=0001 slot0=%h hc=1",
                        bus_if.slot_valid, bus_if.slot_data[31:0], bus_if.hit_count, oam[5]);
    end
  endtask

  task automatic test_busy_trigger();
    int pulses = 0;
    int first  = -1;
    clear_oam();
    oam[0] = make_entry(0, 1'b1, 10'd300);
    oam[7] = make_entry(7, 1'b1, 10'd300);
    @(negedge clk);
    x_i = 10'd640;
    y_i = 10'd305;
    @(posedge clk);
    for (int n = 1; n <= 25; n++) begin
      @(posedge clk); #1;
      if (n == 2) x_i = 10'd641;
      if (n == 1) begin
        tests_run++;
        if (bus_if.scan_busy !== 1'b1) begin
          fails++; $display("FAIL busy_flag: got %b expected 1", bus_if.scan_busy);
        end
      end
      if (bus_if.line_ready === 1'b1) begin
        pulses++;
        if (first < 0) first = n;
      end
    end
    tests_run++;
    if (pulses !== 1 || first !== 10) begin
      fails++; $display("FAIL busy_retrigger: got pulses=%0d first=%0d expected pulses=1 first=10", pulses, first);
    end
    tests_run++;
    if (bus_if.slot_data[63:0] !== {oam[7], oam[0]} || bus_if.slot_valid !== 4'b0011) begin
      fails++; $display("FAIL busy_slots: got valid=%b data=%h expected valid=0011 data=%h",
                        bus_if.slot_valid, bus_if.slot_data[63:0], {oam[7], oam[0]});
    end
  endtask

  task automatic test_reset_midscan();
    int lat;
    clear_oam();
    oam[2] = make_entry(2, 1'b1, 10'd100);
    @(negedge clk);
    x_i = 10'd640;
    y_i = 10'd99;
    @(posedge clk);
    @(negedge clk);
    x_i = 10'd641;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus_if.slot_valid !== 4'b0000 || bus_if.slot_data !== 128'd0 || bus_if.hit_count !== 3'd0 ||
        bus_if.scan_busy !== 1'b0 || bus_if.oam_addr !== 3'd0) begin
      fails++; $display("FAIL midscan_reset: got valid=%b hc=%0d busy=%b addr=%0d expected all 0",
                        bus_if.slot_valid, bus_if.hit_count, bus_if.scan_busy, bus_if.oam_addr);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_line(10'd99, lat);
    tests_run++;
    if (lat !== 10 || bus_if.slot_valid !== 4'b0001 || bus_if.slot_data[31:0] !== oam[2] ||
        bus_if.hit_count !== 3'd1 || bus_if.overflow !== 1'b0) begin
      fails++; $display("FAIL midscan_rescan: got lat=%0d valid=%b slot0=%h hc=%0d ovf=%b expected lat=10 valid=0001 slot0=%h hc=1 ovf=0",
                        lat, bus_if.slot_valid, bus_if.slot_data[31:0], bus_if.hit_count, bus_if.overflow, oam[2]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    x_i   = 10'd0;
    y_i   = 10'd0;
    clear_oam();
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_single_hit();
    test_overflow();
    test_blank_line();
    test_boundaries();
    test_wrap();
    test_busy_trigger();
    test_reset_midscan();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
`default_nettype wire
